// File: rtl/jtbubl_sndcomm_if.sv
// rtl/jtbubl_sndcomm_if.sv - sound-CPU mailbox bus bundle
//
// Groups every non-clock/reset signal of jtbubl_sndcomm.
//   master : drives the block's inputs (sound CPU, main CPU side, timing)
//   slave  : the mailbox block itself
// Signals:
//   cen3        sound CPU clock enable (NMI timing only)
//   snd_rstn    synchronous soft reset, active-low
//   cs/addr     sound CPU select and address [1:0]
//   rd_n/wr_n   sound CPU strobes, active-low
//   cpu_dout    sound CPU write data
//   dout        registered read data back to the sound CPU
//   snd_latch   command byte from the main CPU, snd_stb its write level
//   main_flag   main-side reply-pending flag (status read only)
//   main_latch  reply byte toward the main CPU, main_stb one-cycle pulse
//   snd_flag    command received and not yet read
//   nmi_n       NMI to the sound CPU, active-low
interface jtbubl_sndcomm_if;
  logic       cen3;
  logic       snd_rstn;
  logic       cs;
  logic [1:0] addr;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] cpu_dout;
  logic [7:0] dout;
  logic [7:0] snd_latch;
  logic       snd_stb;
  logic       main_flag;
  logic [7:0] main_latch;
  logic       main_stb;
  logic       snd_flag;
  logic       nmi_n;

  modport master (
    output cen3, snd_rstn, cs, addr, rd_n, wr_n, cpu_dout,
           snd_latch, snd_stb, main_flag,
    input  dout, main_latch, main_stb, snd_flag, nmi_n
  );

  modport slave (
    input  cen3, snd_rstn, cs, addr, rd_n, wr_n, cpu_dout,
           snd_latch, snd_stb, main_flag,
    output dout, main_latch, main_stb, snd_flag, nmi_n
  );
endinterface

// File: rtl/jtbubl_sndcomm.sv
// rtl/jtbubl_sndcomm.sv - sound-CPU end of the main/sound mailbox with timed NMI
//
// Captures the main CPU command byte, flags it to the sound CPU, produces a
// timed NMI when enabled, and exposes a 4-address register window:
//   read  0: command byte (first read cycle clears snd_flag)
//   read  1: {6'h3F, main_flag, snd_flag}
//   read  2/3: FF
//   write 0: reply byte -> main_latch, one-cycle main_stb
//   write 1: NMI enable, write 2: NMI disable, write 3: drop queued NMI
// Ports:
//   clk24  system clock
//   rst    asynchronous active-high reset
//   bus    jtbubl_sndcomm_if.slave, all mailbox/CPU/NMI signals
module jtbubl_sndcomm #(
  parameter int NMI_LEN  = 8,
  parameter int NMI_HOLD = 4
) (
  input  logic                   clk24,
  input  logic                   rst,
  jtbubl_sndcomm_if.slave        bus
);

  localparam logic [7:0] LEN_M1  = 8'(NMI_LEN - 1);
  localparam logic [7:0] HOLD_M1 = 8'(NMI_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } nmi_state_t;

  // Mailbox registers
  logic [7:0] rx_q, rx_d;
  logic       snd_flag_q, snd_flag_d;
  logic       nmi_en_q, nmi_en_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] main_latch_q, main_latch_d;
  logic       main_stb_q, main_stb_d;

  // Previous levels for edge detection
  logic       stb_q, stb_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;

  // NMI timer
  nmi_state_t state_q;
  logic [7:0] cnt_q;
  logic       nmi_n_q;

  logic rd_act, wr_act;
  logic stb_edge, rd_evt, wr_evt;
  logic nmi_fire;

  assign rd_act   = bus.cs & ~bus.rd_n;
  assign wr_act   = bus.cs & ~bus.wr_n;
  assign stb_edge = bus.snd_stb & ~stb_q;
  assign rd_evt   = rd_act & ~rd_q;
  assign wr_evt   = wr_act & ~wr_q;
  assign nmi_fire = (state_q == ST_IDLE) & nmi_pend_q & nmi_en_q;

  always_comb begin
    rx_d         = rx_q;
    snd_flag_d   = snd_flag_q;
    nmi_en_d     = nmi_en_q;
    nmi_pend_d   = nmi_pend_q;
    dout_d       = dout_q;
    main_latch_d = main_latch_q;
    main_stb_d   = 1'b0;
    stb_d        = bus.snd_stb;
    rd_d         = rd_act;
    wr_d         = wr_act;

    // Read data follows the bus every cycle the strobe is low; rx_q is the
    // pre-update value, so a command landing this cycle is not yet visible.
    if (rd_act) begin
      case (bus.addr)
        2'd0:    dout_d = rx_q;
        2'd1:    dout_d = {6'h3F, bus.main_flag, snd_flag_q};
        default: dout_d = 8'hFF;
      endcase
    end

    if (rd_evt && bus.addr == 2'd0) snd_flag_d = 1'b0;

    if (wr_evt) begin
      case (bus.addr)
        2'd0: begin
          main_latch_d = bus.cpu_dout;
          main_stb_d   = 1'b1;
        end
        2'd1:    nmi_en_d   = 1'b1;
        2'd2:    nmi_en_d   = 1'b0;
        default: nmi_pend_d = 1'b0;
      endcase
    end

    if (nmi_fire) nmi_pend_d = 1'b0;

    // A new command wins over any clear in the same cycle.
    if (stb_edge) begin
      rx_d       = bus.snd_latch;
      snd_flag_d = 1'b1;
      nmi_pend_d = 1'b1;
    end

    // Soft reset; edge registers primed high so held levels are not edges.
    if (!bus.snd_rstn) begin
      rx_d         = 8'h00;
      snd_flag_d   = 1'b0;
      nmi_en_d     = 1'b0;
      nmi_pend_d   = 1'b0;
      dout_d       = 8'hFF;
      main_latch_d = 8'h00;
      main_stb_d   = 1'b0;
      stb_d        = 1'b1;
      rd_d         = 1'b1;
      wr_d         = 1'b1;
    end
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      rx_q         <= 8'h00;
      snd_flag_q   <= 1'b0;
      nmi_en_q     <= 1'b0;
      nmi_pend_q   <= 1'b0;
      dout_q       <= 8'hFF;
      main_latch_q <= 8'h00;
      main_stb_q   <= 1'b0;
      stb_q        <= 1'b1;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
    end else begin
      rx_q         <= rx_d;
      snd_flag_q   <= snd_flag_d;
      nmi_en_q     <= nmi_en_d;
      nmi_pend_q   <= nmi_pend_d;
      dout_q       <= dout_d;
      main_latch_q <= main_latch_d;
      main_stb_q   <= main_stb_d;
      stb_q        <= stb_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  // NMI pulse generator. Disabling only gates the IDLE->ASSERT step, so a
  // pulse in flight always completes its low and hold phases.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      nmi_n_q <= 1'b1;
    end else if (!bus.snd_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      nmi_n_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (nmi_fire) begin
            state_q <= ST_ASSERT;
            nmi_n_q <= 1'b0;
            cnt_q   <= LEN_M1;
          end
        end
        ST_ASSERT: begin
          if (bus.cen3) begin
            if (cnt_q == 8'd0) begin
              state_q <= ST_HOLD;
              nmi_n_q <= 1'b1;
              cnt_q   <= HOLD_M1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.cen3) begin
            if (cnt_q == 8'd0) state_q <= ST_IDLE;
            else               cnt_q   <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
          nmi_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.main_latch = main_latch_q;
  assign bus.main_stb   = main_stb_q;
  assign bus.snd_flag   = snd_flag_q;
  assign bus.nmi_n      = nmi_n_q;

endmodule

// File: doc/jtbubl_sndcomm.md
Name: jtbubl_sndcomm

Overview:
- Sound-CPU end of the main↔sound mailbox.
- Captures the command byte written by the main CPU (snd_latch/snd_stb) and raises snd_flag.
- Generates a timed NMI to the sound Z80 when enabled.
- Exposes a 4-address register window to the sound CPU; sound CPU writes drive main_latch/main_stb back toward the main CPU.

Parameters:
NMI_LEN, 8, NMI low time in cen3 ticks (1..255)
NMI_HOLD, 4, minimum NMI high time in cen3 ticks before the next NMI (1..255)

Ports:
clk24  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cen3  in  1  sound CPU clock enable, used only for NMI timing
snd_rstn  in  1  synchronous soft reset, active-low; mirrors sound CPU reset
cs  in  1  sound CPU chip select for this block
addr  in  2  sound CPU address bits [1:0]
rd_n  in  1  sound CPU read strobe
wr_n  in  1  sound CPU write strobe
cpu_dout  in  8  sound CPU write data
dout  out  8  registered read data to sound CPU
snd_latch  in  8  command byte from main CPU
snd_stb  in  1  main CPU write strobe; level held during the write
main_flag  in  1  main-side "reply pending" flag, status read only
main_latch  out  8  reply byte to main CPU
main_stb  out  1  one-clk24 pulse per reply write
snd_flag  out  1  1 = command received, not yet read by sound CPU
nmi_n  out  1  NMI to sound CPU, active-low

Behaviour:
- Reset: rst (async) or !snd_rstn (sync) sets:
  - dout=FF, main_latch=00, main_stb=0, snd_flag=0, nmi_n=1
  - rx=00, nmi_en=0, nmi_pend=0, state IDLE, counter 0
  - edge detectors primed so a level already high does not count as an edge
- Edge detection, all registered on clk24:
  - stb_edge = snd_stb rising.
  - rd_evt = first cycle of cs&&!rd_n.
  - wr_evt = first cycle of cs&&!wr_n.
  - A strobe held many cycles produces exactly one event.
- stb_edge: rx<=snd_latch, snd_flag<=1, nmi_pend<=1.
- Reads: dout updated every cycle while cs&&!rd_n, one clk24 latency.
  - addr0: returns rx. rd_evt@addr0 clears snd_flag.
  - addr1: returns {6'h3F, main_flag, snd_flag}.
  - addr2/3: return FF.
  - dout holds its last value when not reading.
- Writes, on wr_evt only:
  - addr0: main_latch<=cpu_dout, main_stb=1 for exactly the next clk24 cycle.
  - addr1: nmi_en<=1.
  - addr2: nmi_en<=0.
  - addr3: nmi_pend<=0 (discard queued NMI).
- Simultaneous events:
  - stb_edge with rd_evt@addr0: set wins, snd_flag=1, and dout returns the old rx.
  - stb_edge with wr_evt@addr3: pend set wins.
- NMI FSM, counter 8 bits, decremented only on cen3:
  - IDLE: if nmi_pend&&nmi_en → ASSERT; nmi_n=0, cnt=NMI_LEN-1, nmi_pend<=0, all on the same clk24 edge. A stb_edge in that same cycle re-sets nmi_pend (queued).
  - ASSERT: on cen3, cnt==0 → HOLD with nmi_n=1, cnt=NMI_HOLD-1; else cnt-1.
  - HOLD: on cen3, cnt==0 → IDLE; else cnt-1.
  - nmi_en cleared during ASSERT/HOLD does not truncate the current pulse; it only blocks the next IDLE→ASSERT.
  - Commands arriving during ASSERT/HOLD queue as a single pending NMI.
  - Enabling while pend=1 fires from IDLE one clk24 later.
- snd_rstn low mid-pulse: nmi_n returns to 1 on the next clk24 edge.

Test Plan:
- Reset, then snd_stb high 10 cycles with snd_latch=5A:
  - snd_flag=1 after 1 cycle; addr1 read returns {3F,main_flag,1}.
  - addr0 read returns 5A and clears snd_flag.
- nmi_en=1, one stb edge, cen3 every 8 clk24:
  - nmi_n low for exactly 8 cen3 ticks (64 clk24), then high for at least 4 ticks.
  - Second stb during the pulse gives a second NMI right after HOLD; three stbs during the pulse still give only one extra NMI.
- nmi_en=0, stb edge:
  - no NMI.
  - Write addr1: NMI asserts 1 clk24 after the enable write.
  - Repeat with an addr3 write before the enable: no NMI.
- Sound write addr0=C3 with wr_n low 6 cycles:
  - main_latch=C3; main_stb high exactly 1 cycle, exactly once.
- stb_edge in the same cycle as rd_evt@addr0:
  - snd_flag ends 1; dout returns the previous rx.
- snd_rstn pulsed low during ASSERT:
  - nmi_n=1, snd_flag=0, nmi_en=0 next cycle.
  - An async rst assertion mid-cycle clears the outputs immediately.
